// File: rtl/inst_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit_if
// Bundles the fetch stage's three conversations: redirects from execute,
// the single-outstanding request/response to instruction memory, and the
// valid/ready instruction hand-off to decode.
//   master : the fetch unit (drives imem_req/imem_addr and the inst_* outputs)
//   slave  : the surrounding core/memory (drives redirect, response, ready)
// ---------------------------------------------------------------------------
interface inst_fetch_unit_if;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    modport master (
        input  redirect_en, redirect_pc, imem_rvalid, imem_rdata, inst_ready,
        output imem_req, imem_addr, inst_valid, inst, inst_pc
    );

    modport slave (
        output redirect_en, redirect_pc, imem_rvalid, imem_rdata, inst_ready,
        input  imem_req, imem_addr, inst_valid, inst, inst_pc
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
// RV32I fetch stage. Holds the PC, issues one word request at a time to an
// instruction memory of variable latency, and presents the returned word with
// its PC to decode over valid/ready. Redirects from execute take priority in
// every state; a response belonging to a fetch made obsolete by a redirect is
// drained and discarded.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous, active-high reset
//   bus  : inst_fetch_unit_if.master
//          redirect_en/redirect_pc    - redirect from execute
//          imem_req/imem_addr         - request to memory (addr == pc)
//          imem_rvalid/imem_rdata     - memory response
//          inst_valid/inst/inst_pc    - instruction to decode
//          inst_ready                 - decode accepts
// ---------------------------------------------------------------------------
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst,
    inst_fetch_unit_if.master      bus
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] inst_r;
    logic [31:0] inst_pc_r;
    logic        inst_valid_r;
    logic [31:0] redirect_target_s;

    // Redirect targets are always word aligned; low bits from execute are dropped.
    assign redirect_target_s = {bus.redirect_pc[31:2], 2'b00};

    // Request is suppressed in a redirect cycle so the old pc never goes out.
    assign bus.imem_req   = (state_r == ST_FETCH) && !bus.redirect_en;
    assign bus.imem_addr  = pc_r;
    assign bus.inst_valid = inst_valid_r;
    assign bus.inst       = inst_r;
    assign bus.inst_pc    = inst_pc_r;

    // Fetch sequencer: pc, state and the decode-facing output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_FETCH;
            pc_r         <= RESET_PC;
            inst_r       <= NOP_INST;
            inst_pc_r    <= RESET_PC;
            inst_valid_r <= 1'b0;
        end else if (bus.redirect_en) begin
            pc_r         <= redirect_target_s;
            inst_valid_r <= 1'b0;
            case (state_r)
                // A request is still outstanding unless its response lands now.
                ST_WAIT:  state_r <= bus.imem_rvalid ? ST_FETCH : ST_DRAIN;
                ST_DRAIN: state_r <= ST_DRAIN;
                ST_FETCH: state_r <= ST_FETCH;
                ST_HOLD:  state_r <= ST_FETCH;
                default:  state_r <= ST_FETCH;
            endcase
        end else begin
            case (state_r)
                ST_FETCH: begin
                    // imem_req is necessarily high here (no redirect this cycle).
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.imem_rvalid) begin
                        inst_r       <= bus.imem_rdata;
                        inst_pc_r    <= pc_r;
                        inst_valid_r <= 1'b1;
                        state_r      <= ST_HOLD;
                    end else begin
                        state_r      <= ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (inst_valid_r && bus.inst_ready) begin
                        inst_valid_r <= 1'b0;
                        pc_r         <= pc_r + 32'd4;
                        state_r      <= ST_FETCH;
                    end else begin
                        state_r      <= ST_HOLD;
                    end
                end
                ST_DRAIN: begin
                    // The stale response is swallowed; inst_valid is already 0.
                    if (bus.imem_rvalid) begin
                        state_r <= ST_FETCH;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    state_r <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    inst_fetch_unit_if bus ();
    inst_fetch_unit_if bus2 ();

    inst_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    inst_fetch_unit #(
        .RESET_PC (32'hFFFF_FFFC),
        .NOP_INST (32'h0000_0013)
    ) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.redirect_en  = 1'b0;
        bus.redirect_pc  = 32'h0;
        bus.imem_rvalid  = 1'b0;
        bus.imem_rdata   = 32'h0;
        bus.inst_ready   = 1'b0;
        bus2.redirect_en = 1'b0;
        bus2.redirect_pc = 32'h0;
        bus2.imem_rvalid = 1'b0;
        bus2.imem_rdata  = 32'h0;
        bus2.inst_ready  = 1'b0;
    endtask

    // Hold reset across an edge, then release it 1 ns after the edge.
    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        #2;
        check_eq("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
        check_eq("rst_inst", bus.inst, 32'h0000_0013);
        check_eq("rst_inst_pc", bus.inst_pc, 32'h0);
        check_eq("rst_addr", bus.imem_addr, 32'h0);
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Starts in FETCH; memory answers lat cycles after the request; decode
    // stalls for hold_cycles before accepting. Spurious rvalid is driven
    // during the stall to show it is ignored.
    task automatic fetch_one(input logic [31:0] data, input int lat,
                             input int hold_cycles, input logic [31:0] exp_pc);
        check_eq("req_hi", {31'd0, bus.imem_req}, 32'd1);
        check_eq("req_addr", bus.imem_addr, exp_pc);
        tick();
        for (int i = 0; i < lat - 1; i++) begin
            check_eq("wait_req_lo", {31'd0, bus.imem_req}, 32'd0);
            check_eq("wait_valid_lo", {31'd0, bus.inst_valid}, 32'd0);
            tick();
        end
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = data;
        tick();
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        for (int i = 0; i < hold_cycles; i++) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 32'hBAD0_BAD0;
            #1;
            check_eq("hold_valid", {31'd0, bus.inst_valid}, 32'd1);
            check_eq("hold_inst", bus.inst, data);
            check_eq("hold_pc", bus.inst_pc, exp_pc);
            check_eq("hold_req_lo", {31'd0, bus.imem_req}, 32'd0);
            tick();
        end
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.inst_ready  = 1'b1;
        #1;
        check_eq("out_valid", {31'd0, bus.inst_valid}, 32'd1);
        check_eq("out_inst", bus.inst, data);
        check_eq("out_pc", bus.inst_pc, exp_pc);
        tick();
        bus.inst_ready = 1'b0;
        #1;
        check_eq("acc_valid_lo", {31'd0, bus.inst_valid}, 32'd0);
        check_eq("acc_inst_kept", bus.inst, data);
    endtask

    initial begin
        clk      = 1'b0;
        rst      = 1'b0;
        n_checks = 0;
        n_errors = 0;
        clear_inputs();
        #1;

        // Back-to-back fetches, 1-cycle memory, decode always ready.
        do_reset();
        fetch_one(32'h0050_0093, 1, 0, 32'h0000_0000);
        fetch_one(32'h00A0_0113, 1, 0, 32'h0000_0004);
        fetch_one(32'h0020_81B3, 1, 0, 32'h0000_0008);
        check_eq("seq_next_addr", bus.imem_addr, 32'h0000_000C);

        // Slow memory plus decode stall.
        do_reset();
        fetch_one(32'h0050_0093, 4, 5, 32'h0000_0000);
        check_eq("stall_next_req", {31'd0, bus.imem_req}, 32'd1);
        check_eq("stall_next_addr", bus.imem_addr, 32'h0000_0004);

        // Redirect while waiting; the stale response must be drained.
        do_reset();
        tick();
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 32'h0000_0103;
        #1;
        check_eq("wait_redir_req_lo", {31'd0, bus.imem_req}, 32'd0);
        tick();
        bus.redirect_en = 1'b0;
        bus.redirect_pc = 32'h0;
        #1;
        check_eq("drain_addr", bus.imem_addr, 32'h0000_0100);
        check_eq("drain_req_lo", {31'd0, bus.imem_req}, 32'd0);
        check_eq("drain_valid_lo", {31'd0, bus.inst_valid}, 32'd0);
        tick();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        #1;
        check_eq("drain_req_lo2", {31'd0, bus.imem_req}, 32'd0);
        tick();
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        #1;
        check_eq("drain_dropped_valid", {31'd0, bus.inst_valid}, 32'd0);
        check_eq("drain_dropped_inst", bus.inst, 32'h0000_0013);
        fetch_one(32'h1111_1111, 1, 0, 32'h0000_0100);

        // Redirect in HOLD colliding with inst_ready; redirect wins.
        do_reset();
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 32'h0000_0020;
        tick();
        bus.redirect_en = 1'b0;
        bus.redirect_pc = 32'h0;
        #1;
        check_eq("hr_req_addr", bus.imem_addr, 32'h0000_0020);
        tick();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h0000_0073;
        tick();
        bus.imem_rvalid = 1'b0;
        #1;
        check_eq("hr_hold_valid", {31'd0, bus.inst_valid}, 32'd1);
        check_eq("hr_hold_pc", bus.inst_pc, 32'h0000_0020);
        bus.inst_ready  = 1'b1;
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 32'h0000_0080;
        tick();
        bus.inst_ready  = 1'b0;
        bus.redirect_en = 1'b0;
        bus.redirect_pc = 32'h0;
        #1;
        check_eq("hr_valid_lo", {31'd0, bus.inst_valid}, 32'd0);
        check_eq("hr_req", {31'd0, bus.imem_req}, 32'd1);
        check_eq("hr_addr", bus.imem_addr, 32'h0000_0080);

        // PC wrap from 0xFFFF_FFFC on the second instance.
        do_reset();
        check_eq("wrap_req", {31'd0, bus2.imem_req}, 32'd1);
        check_eq("wrap_addr0", bus2.imem_addr, 32'hFFFF_FFFC);
        tick();
        bus2.imem_rvalid = 1'b1;
        bus2.imem_rdata  = 32'h0050_0093;
        tick();
        bus2.imem_rvalid = 1'b0;
        bus2.inst_ready  = 1'b1;
        #1;
        check_eq("wrap_valid", {31'd0, bus2.inst_valid}, 32'd1);
        check_eq("wrap_inst_pc", bus2.inst_pc, 32'hFFFF_FFFC);
        tick();
        bus2.inst_ready = 1'b0;
        #1;
        check_eq("wrap_addr1", bus2.imem_addr, 32'h0000_0000);
        check_eq("wrap_req1", {31'd0, bus2.imem_req}, 32'd1);

        // Asynchronous reset in the middle of WAIT, no clock edge needed.
        do_reset();
        fetch_one(32'h0050_0093, 1, 0, 32'h0000_0000);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_valid", {31'd0, bus.inst_valid}, 32'd0);
        check_eq("arst_inst", bus.inst, 32'h0000_0013);
        check_eq("arst_inst_pc", bus.inst_pc, 32'h0);
        check_eq("arst_addr", bus.imem_addr, 32'h0);
        check_eq("arst_req", {31'd0, bus.imem_req}, 32'd1);
        tick();
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Fetch stage directly upstream of the immediate generator and decode logic in the RV32I core.
- Holds the PC and issues one word request at a time to instruction memory, which has variable response latency.
- Presents the returned instruction with its PC to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute and discards any in-flight fetch made obsolete by a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, value driven on inst while no instruction has been fetched (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- redirect_en  in  1  load redirect_pc into the PC; flush fetch.
- redirect_pc  in  32  target PC; bits [1:0] are ignored and forced to 0.
- imem_req  out  1  request strobe; memory accepts it in the same cycle.
- imem_addr  out  32  word address of the request (equals pc).
- imem_rvalid  in  1  response valid, at least 1 cycle after imem_req.
- imem_rdata  in  32  instruction word, qualified by imem_rvalid.
- inst_valid  out  1  inst and inst_pc hold a fetched instruction.
- inst_ready  in  1  decode accepts the instruction.
- inst  out  32  fetched instruction, consumed by the immediate generator and decode.
- inst_pc  out  32  PC of inst.

Behaviour:
- Reset (asynchronous assert; release is synchronous to clk):
  - state=FETCH, pc=RESET_PC, inst_valid=0, inst=NOP_INST, inst_pc=RESET_PC.
  - imem_req may assert in the first cycle after reset releases.
- Registers: 32-bit pc, output registers inst/inst_pc/inst_valid, 2-bit state (FETCH, WAIT, HOLD, DRAIN).
- Outputs:
  - imem_addr = pc at all times.
  - imem_req = (state==FETCH) && !redirect_en. Combinational; exactly one outstanding request at any time.
- FETCH:
  - If imem_req is asserted, go to WAIT next cycle.
- WAIT:
  - On imem_rvalid: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, go to HOLD.
  - Otherwise stay in WAIT; there is no timeout.
- HOLD:
  - inst/inst_pc/inst_valid stay stable until accepted.
  - On inst_valid && inst_ready: inst_valid<=0, pc<=pc+4 (mod 2^32; 0xFFFF_FFFC wraps to 0), go to FETCH.
  - inst keeps its last value after acceptance.
- Latency and throughput:
  - Request to inst_valid = memory latency + 1 cycle (the capture register).
  - Peak rate is one instruction per 3 cycles with 1-cycle memory and ready held high.
- Redirect (highest priority, any state):
  - pc<={redirect_pc[31:2],2'b00}, inst_valid<=0; no pc+4 that cycle.
  - Next state:
    - WAIT without imem_rvalid this cycle: go to DRAIN.
    - WAIT with imem_rvalid this cycle: data is dropped, go to FETCH.
    - DRAIN: stay in DRAIN.
    - FETCH or HOLD: go to FETCH.
  - Redirect coinciding with inst_ready in HOLD: the handshake is void and the redirect wins.
- DRAIN:
  - imem_req=0. On imem_rvalid the data is discarded and the state goes to FETCH.
  - inst_valid stays 0 throughout.
- imem_rvalid in FETCH or HOLD is spurious and ignored; no state or output changes.
- Reset mid-operation: all state clears immediately. Flushing responses already in flight in memory is the memory side's responsibility.
- inst_ready with inst_valid=0 has no effect.

Test Plan:
- Reset release, 1-cycle memory returning 0x00500093, 0x00A00113, 0x002081B3; inst_ready=1 -> inst_pc 0x0, 0x4, 0x8 with matching inst; inst_valid pulses 1 cycle each, 3 cycles apart; imem_addr steps 0,4,8.
- Memory latency 4 cycles, inst_ready low for 5 cycles after valid -> inst=0x00500093 and inst_pc=0x0 stable throughout HOLD; no second imem_req until acceptance; then imem_addr=0x4.
- redirect_en with redirect_pc=0x0000_0103 in WAIT, response 0xDEADBEEF arrives 2 cycles later -> 0xDEADBEEF never appears with inst_valid=1; next imem_addr=0x0000_0100; inst_valid=0 throughout DRAIN.
- redirect_en in HOLD on the same cycle as inst_ready, pc=0x20, redirect_pc=0x80 -> inst_valid drops; next fetch at 0x80 (not 0x24).
- RESET_PC=0xFFFF_FFFC, first instruction accepted -> next imem_addr=0x0000_0000.
- rst asserted asynchronously mid-WAIT -> inst_valid=0, inst=0x0000_0013, and pc=RESET_PC within the same cycle, without waiting for a clk edge.
